// File: rtl/byte_pattern_matcher.sv
// byte_pattern_matcher
//   Streaming byte comparator. A bitwise XNOR against a loaded pattern gives a
//   per-bit equality vector. Masked bits are forced to "equal" before the
//   vector is reduced to a byte match. The block counts consecutive matching
//   valid bytes, pulses outMatch once when the run reaches the threshold, and
//   keeps a saturating count of those pulses.
//
//   Ports
//     clk, rst      rising-edge clock, asynchronous active-high reset
//     inLoad        capture inPattern / inMask / inThreshold and restart the run
//     inPattern     pattern byte
//     inMask        care mask (1 = bit compared)
//     inThreshold   required run length (0 is treated as 1)
//     inClear       zero the hit counter
//     inValid       inData carries a byte this cycle
//     inData        streamed byte
//     outEqual      masked equality vector of the last valid byte
//     outByteMatch  last valid byte matched
//     outRunCount   current consecutive-match count (saturating)
//     outMatch      one-cycle pulse when the run reaches the threshold
//     outHitCount   saturating count of outMatch pulses
//     outState      0 IDLE, 1 RUN, 2 HIT

module xnor_gate_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] y
);
    assign y = ~(a ^ b);
endmodule

module byte_pattern_matcher #(
    parameter int RUN_W     = 4,
    parameter int HIT_W     = 8,
    parameter int RETRIGGER = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inLoad,
    input  logic [7:0]       inPattern,
    input  logic [7:0]       inMask,
    input  logic [RUN_W-1:0] inThreshold,
    input  logic             inClear,
    input  logic             inValid,
    input  logic [7:0]       inData,
    output logic [7:0]       outEqual,
    output logic             outByteMatch,
    output logic [RUN_W-1:0] outRunCount,
    output logic             outMatch,
    output logic [HIT_W-1:0] outHitCount,
    output logic [1:0]       outState
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HIT = 2'd2} state_t;

    localparam logic [RUN_W-1:0] RUN_MAX = '1;
    localparam logic [HIT_W-1:0] HIT_MAX = '1;

    state_t           state;
    logic [7:0]       patternReg, maskReg;
    logic [RUN_W-1:0] thrReg, run;
    logic [7:0]       xnorEq, eq;
    logic             byteMatch, reach;
    logic [RUN_W-1:0] thr, runSat;
    logic [RUN_W:0]   runNext;

    xnor_gate_8bit u_xnor (.a(inData), .b(patternReg), .y(xnorEq));

    assign eq        = xnorEq | ~maskReg;
    assign byteMatch = &eq;
    assign thr       = (thrReg == '0) ? RUN_W'(1) : thrReg;
    // One bit wider so run+1 never wraps before the threshold compare.
    assign runNext   = {1'b0, run} + (RUN_W+1)'(1);
    assign runSat    = (run == RUN_MAX) ? RUN_MAX : runNext[RUN_W-1:0];

    // IDLE uses >= so a threshold of 1 fires on the first byte of a run;
    // HIT never fires again until the run is broken.
    always_comb begin
        reach = 1'b0;
        case (state)
            IDLE:    reach = (runNext >= {1'b0, thr});
            RUN:     reach = (runNext == {1'b0, thr});
            default: reach = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            patternReg   <= 8'h00;
            maskReg      <= 8'hFF;
            thrReg       <= RUN_W'(1);
            run          <= '0;
            outEqual     <= 8'h00;
            outByteMatch <= 1'b0;
            outMatch     <= 1'b0;
            outHitCount  <= '0;
        end else begin
            outMatch <= 1'b0;

            // Counts the pulse currently on outMatch; a clear that lands on a
            // pulse keeps that pulse.
            if (inClear)
                outHitCount <= {{(HIT_W-1){1'b0}}, outMatch};
            else if (outMatch && outHitCount != HIT_MAX)
                outHitCount <= outHitCount + HIT_W'(1);

            if (inLoad) begin
                patternReg <= inPattern;
                maskReg    <= inMask;
                thrReg     <= inThreshold;
                run        <= '0;
                state      <= IDLE;
            end else if (inValid) begin
                outEqual     <= eq;
                outByteMatch <= byteMatch;
                if (!byteMatch) begin
                    run   <= '0;
                    state <= IDLE;
                end else if (reach) begin
                    outMatch <= 1'b1;
                    if (RETRIGGER != 0) begin
                        run   <= '0;
                        state <= IDLE;
                    end else begin
                        run   <= runSat;
                        state <= HIT;
                    end
                end else begin
                    run   <= runSat;
                    state <= (state == HIT) ? HIT : RUN;
                end
            end
        end
    end

    assign outRunCount = run;
    assign outState    = state;
endmodule

// File: tb/tb_byte_pattern_matcher.sv
module tb_byte_pattern_matcher;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inLoad = 1'b0, inClear = 1'b0, inValid = 1'b0;
    logic [7:0] inPattern = 8'h00, inMask = 8'h00, inData = 8'h00;
    logic [3:0] inThreshold = 4'd0;

    logic [7:0] eq0, eq1;
    logic       bm0, bm1, m0, m1;
    logic [3:0] run0, run1;
    logic [7:0] hit0, hit1;
    logic [1:0] st0, st1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    byte_pattern_matcher #(.RUN_W(4), .HIT_W(8), .RETRIGGER(0)) dut0 (
        .clk(clk), .rst(rst), .inLoad(inLoad), .inPattern(inPattern), .inMask(inMask),
        .inThreshold(inThreshold), .inClear(inClear), .inValid(inValid), .inData(inData),
        .outEqual(eq0), .outByteMatch(bm0), .outRunCount(run0), .outMatch(m0),
        .outHitCount(hit0), .outState(st0));

    byte_pattern_matcher #(.RUN_W(4), .HIT_W(8), .RETRIGGER(1)) dut1 (
        .clk(clk), .rst(rst), .inLoad(inLoad), .inPattern(inPattern), .inMask(inMask),
        .inThreshold(inThreshold), .inClear(inClear), .inValid(inValid), .inData(inData),
        .outEqual(eq1), .outByteMatch(bm1), .outRunCount(run1), .outMatch(m1),
        .outHitCount(hit1), .outState(st1));

    typedef struct {
        logic       ld;
        logic [7:0] pat;
        logic [7:0] msk;
        logic [3:0] thr;
        logic       clr;
        logic       vld;
        logic [7:0] dat;
        logic [7:0] eq;
        logic       bm;
        logic [3:0] run;
        logic       m;
        logic [1:0] st;
        logic [7:0] hit;
    } vec_t;

    vec_t tbl [25];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic [7:0] pat, input logic [7:0] msk,
                         input logic [3:0] thr, input logic clr, input logic vld,
                         input logic [7:0] dat);
        inLoad = ld; inPattern = pat; inMask = msk; inThreshold = thr;
        inClear = clr; inValid = vld; inData = dat;
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ld pat msk thr clr vld dat | eq bm run m st hit
        tbl[0]  = '{1'b1, 8'hA5, 8'hFF, 4'd3, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0, 1'b0, 2'd0, 8'd0};
        tbl[1]  = '{1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 8'hA5, 8'hFF, 1'b1, 4'd1, 1'b0, 2'd1, 8'd0};
        tbl[2]  = '{1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 8'hA5, 8'hFF, 1'b1, 4'd2, 1'b0, 2'd1, 8'd0};
        tbl[3]  = '{1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 8'hA5, 8'hFF, 1'b1, 4'd3, 1'b1, 2'd2, 8'd0};
        tbl[4]  = '{1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 8'hA5, 8'hFF, 1'b1, 4'd4, 1'b0, 2'd2, 8'd1};
        tbl[5]  = '{1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 8'h3C, 8'hFF, 1'b1, 4'd4, 1'b0, 2'd2, 8'd1};
        tbl[6]  = '{1'b1, 8'hA5, 8'hFF, 4'd3, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, 4'd0, 1'b0, 2'd0, 8'd1};
        tbl[7]  = '{1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 8'hA5, 8'hFF, 1'b1, 4'd1, 1'b0, 2'd1, 8'd1};
        tbl[8]  = '{1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 8'hA5, 8'hFF, 1'b1, 4'd2, 1'b0, 2'd1, 8'd1};
        tbl[9]  = '{1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 8'h3C, 8'h66, 1'b0, 4'd0, 1'b0, 2'd0, 8'd1};
        tbl[10] = '{1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 8'hA5, 8'hFF, 1'b1, 4'd1, 1'b0, 2'd1, 8'd1};
        tbl[11] = '{1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 8'hA5, 8'hFF, 1'b1, 4'd2, 1'b0, 2'd1, 8'd1};
        tbl[12] = '{1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 8'hA5, 8'hFF, 1'b1, 4'd3, 1'b1, 2'd2, 8'd1};
        tbl[13] = '{1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, 4'd3, 1'b0, 2'd2, 8'd2};
        tbl[14] = '{1'b1, 8'hF0, 8'hF0, 4'd2, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, 4'd0, 1'b0, 2'd0, 8'd2};
        tbl[15] = '{1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 8'hF3, 8'hFF, 1'b1, 4'd1, 1'b0, 2'd1, 8'd2};
        tbl[16] = '{1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 8'hFC, 8'hFF, 1'b1, 4'd2, 1'b1, 2'd2, 8'd2};
        tbl[17] = '{1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, 4'd2, 1'b0, 2'd2, 8'd3};
        tbl[18] = '{1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 8'h00, 8'h0F, 1'b0, 4'd0, 1'b0, 2'd0, 8'd3};
        // load wins over a matching valid byte in the same cycle
        tbl[19] = '{1'b1, 8'hA5, 8'hFF, 4'd2, 1'b0, 1'b1, 8'hA5, 8'h0F, 1'b0, 4'd0, 1'b0, 2'd0, 8'd3};
        tbl[20] = '{1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 8'hA5, 8'hFF, 1'b1, 4'd1, 1'b0, 2'd1, 8'd3};
        // mask 00 matches anything; threshold 0 behaves as 1
        tbl[21] = '{1'b1, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, 4'd0, 1'b0, 2'd0, 8'd3};
        tbl[22] = '{1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 8'h5A, 8'hFF, 1'b1, 4'd1, 1'b1, 2'd2, 8'd3};
        tbl[23] = '{1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 8'h77, 8'hFF, 1'b1, 4'd2, 1'b0, 2'd2, 8'd4};
        tbl[24] = '{1'b0, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b1, 4'd2, 1'b0, 2'd2, 8'd0};

        // reset state
        #2;
        chk("rst.eq", 32'(eq0), 32'h00);
        chk("rst.bm", 32'(bm0), 32'h0);
        chk("rst.run", 32'(run0), 32'h0);
        chk("rst.m", 32'(m0), 32'h0);
        chk("rst.hit", 32'(hit0), 32'h0);
        chk("rst.st", 32'(st0), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].ld, tbl[i].pat, tbl[i].msk, tbl[i].thr, tbl[i].clr, tbl[i].vld, tbl[i].dat);
            tick();
            chk($sformatf("v%0d.eq", i), 32'(eq0), 32'(tbl[i].eq));
            chk($sformatf("v%0d.bm", i), 32'(bm0), 32'(tbl[i].bm));
            chk($sformatf("v%0d.run", i), 32'(run0), 32'(tbl[i].run));
            chk($sformatf("v%0d.m", i), 32'(m0), 32'(tbl[i].m));
            chk($sformatf("v%0d.st", i), 32'(st0), 32'(tbl[i].st));
            chk($sformatf("v%0d.hit", i), 32'(hit0), 32'(tbl[i].hit));
        end

        // run counter saturates at 15 and stays in HIT without pulsing
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 8'h00);
            tick();
        end
        chk("runsat.run", 32'(run0), 32'd15);
        chk("runsat.st", 32'(st0), 32'd2);
        chk("runsat.m", 32'(m0), 32'd0);

        // asynchronous reset mid-run
        drive(1'b1, 8'hA5, 8'hFF, 4'd3, 1'b0, 1'b0, 8'h00);
        tick();
        drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 8'hA5);
        tick();
        tick();
        chk("midrun.run", 32'(run0), 32'd2);
        rst = 1'b1;
        #1;
        chk("arst.eq", 32'(eq0), 32'h00);
        chk("arst.bm", 32'(bm0), 32'h0);
        chk("arst.run", 32'(run0), 32'h0);
        chk("arst.st", 32'(st0), 32'h0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        // default config: pattern 00, mask FF, threshold 1
        drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 8'h0F);
        tick();
        chk("dflt.eq", 32'(eq0), 32'hF0);
        chk("dflt.bm", 32'(bm0), 32'h0);
        drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 8'h00);
        tick();
        chk("dflt.m", 32'(m0), 32'h1);
        chk("dflt.st", 32'(st0), 32'd2);
        idle();
        tick();
        chk("dflt.hit", 32'(hit0), 32'd1);

        // retrigger: thr=2, six matching bytes pulse after 2, 4 and 6
        drive(1'b1, 8'h3C, 8'hFF, 4'd2, 1'b1, 1'b0, 8'h00);
        tick();
        chk("rt.hit0", 32'(hit1), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 8'h3C);
            tick();
            chk($sformatf("rt%0d.m", k), 32'(m1), 32'((k % 2) == 0));
            chk($sformatf("rt%0d.run", k), 32'(run1), 32'(k % 2));
            chk($sformatf("rt%0d.st", k), 32'(st1), 32'(k % 2));
        end
        idle();
        tick();
        chk("rt.hit", 32'(hit1), 32'd3);

        // hit counter saturation, then clear coinciding with a pulse
        drive(1'b1, 8'h00, 8'h00, 4'd1, 1'b1, 1'b0, 8'h00);
        tick();
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 8'($urandom_range(0, 255)));
            tick();
        end
        chk("sat.hit", 32'(hit1), 32'd255);
        chk("sat.m", 32'(m1), 32'd1);
        drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0, 8'h00);
        tick();
        chk("clrpulse.hit", 32'(hit1), 32'd1);
        chk("clrpulse.m", 32'(m1), 32'd0);
        idle();
        tick();
        chk("clrhold.hit", 32'(hit1), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/byte_pattern_matcher.md
Name: byte_pattern_matcher

Overview:
- Streaming byte comparator that sits directly downstream of xnor_gate_8bit.
- Instantiates one xnor_gate_8bit and uses its per-bit equality vector to detect runs of consecutive incoming bytes that equal a programmable, maskable pattern.
- Flags when a run reaches a programmable length and keeps a saturating hit count.
- Used as the match/trigger stage behind the bitwise logic gates in the datapath test designs.

Parameters:
- RUN_W, 4, width of run counter and threshold (max run 2^RUN_W-1).
- HIT_W, 8, width of saturating hit counter.
- RETRIGGER, 0, 0 = one pulse per run; 1 = re-arm immediately after each pulse.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- inLoad  input  1  load pattern/mask/threshold registers this cycle.
- inPattern  input  8  pattern value, captured on inLoad.
- inMask  input  8  care mask, 1 = bit compared, captured on inLoad.
- inThreshold  input  RUN_W  required run length, captured on inLoad.
- inClear  input  1  clear hit counter.
- inValid  input  1  inData valid this cycle.
- inData  input  8  streamed byte.
- outEqual  output  8  registered masked equality vector of the last valid byte.
- outByteMatch  output  1  registered: last valid byte matched.
- outRunCount  output  RUN_W  current consecutive-match count.
- outMatch  output  1  one-cycle pulse when run reaches threshold.
- outHitCount  output  HIT_W  saturating count of outMatch pulses.
- outState  output  2  FSM state: 0 IDLE, 1 RUN, 2 HIT.

Behaviour:
- Reset (async, rst=1):
  - Outputs: outEqual=0, outByteMatch=0, outRunCount=0, outMatch=0, outHitCount=0, outState=IDLE.
  - Internal registers: pattern=0x00, mask=0xFF, threshold=1.
- Compare (combinational, inside the block):
  - eq = xnor_gate_8bit(inData, patternReg) | ~maskReg.
  - byteMatch = &eq.
  - mask=0x00 makes every byte match.
- Effective threshold thr = (thresholdReg==0) ? 1 : thresholdReg.
- Load:
  - inLoad=1 captures inPattern, inMask and inThreshold.
  - Forces run=0, state=IDLE, outMatch=0.
  - Has priority over inValid in the same cycle; that byte is discarded and outEqual/outByteMatch hold.
- Valid byte (inValid=1, inLoad=0):
  - outEqual <= eq and outByteMatch <= byteMatch (1-cycle latency).
  - On match: run <= run+1, saturating at 2^RUN_W-1.
  - On mismatch: run <= 0 and state <= IDLE.
- inValid=0: run, state, outEqual and outByteMatch hold; outMatch=0.
- FSM:
  - IDLE: on match, if run+1 >= thr go to HIT and pulse, else go to RUN.
  - RUN: on match, if run+1 == thr go to HIT and pulse; on mismatch go to IDLE.
  - HIT, RETRIGGER=0: matches keep incrementing run (saturating) with no further pulses; a mismatch returns to IDLE.
  - RETRIGGER=1: in the cycle of the pulse, run <= 0 and state <= IDLE instead of HIT, so every thr consecutive matches pulse again.
- outMatch:
  - Registered; asserted exactly one cycle, in the cycle after the threshold-reaching byte.
  - This is the same cycle outRunCount first shows thr (or 0 with RETRIGGER=1).
- Hit counter:
  - Increments on each outMatch pulse, saturating at 2^HIT_W-1.
  - inClear zeroes it.
  - If inClear and a pulse occur in the same cycle, the result is 1.
- Reset mid-run: everything returns to reset values immediately, and the loaded configuration is lost.

Test Plan:
- Reset then load pattern=0xA5, mask=0xFF, thr=3; stream A5,A5,A5,A5 -> outMatch pulses once, one cycle after the 3rd byte; outRunCount=4; outHitCount=1; outState=HIT.
- Same configuration; stream A5,A5,3C,A5,A5,A5 -> run 1,2,0,1,2,3; exactly one pulse after the 6th byte; outEqual after 3C = 0x66.
- Load pattern=0xF0, mask=0xF0, thr=2; stream F3,FC -> both match; pulse after FC; outEqual=0xFF both cycles.
- RETRIGGER=1, thr=2; stream 6 matching bytes -> pulses after bytes 2, 4 and 6; outHitCount=3.
- Saturation: thr=1, RETRIGGER=1, 300 matching bytes -> outHitCount=255; then inClear together with a pulse -> outHitCount=1.
- Priority and reset:
  - inLoad with inValid and a matching byte in the same cycle -> byte ignored, run=0.
  - rst asserted mid-run at run=2 -> all outputs 0 asynchronously, mask back to 0xFF.
